// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared enable-gated register.
// Optional requester locking is built when REG_WRITE_ARB_LOCK_EN is defined.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req       per-requester write request
//   wdata     flattened write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lock      per-requester lock request (used only when the lock feature is built)
//   ack       registered one-hot write acknowledge
//   grant_id  registered index of the most recent winner
//   reg_q     shared register contents
//   busy      registered, high after an edge that performed a write
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_REQ-1:0]            lock,
    output logic [NUM_REQ-1:0]            ack,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [DATA_WIDTH-1:0]         reg_q,
    output logic                          busy
);

    logic [DATA_WIDTH-1:0] wd [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_wd
        assign wd[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_REQ-1:0]  elig;
    logic                found;
    logic [ID_WIDTH-1:0] win;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] nxt_ptr;
    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;

`ifdef REG_WRITE_ARB_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] lock_id;
    logic                hold;

    // Dropping lock[lock_id] releases the lock on the same edge, so the
    // round-robin search already applies at the unlocking edge.
    assign hold = (state == LOCKED) && lock[lock_id];
    assign elig = hold ? (req & ~ack & (NUM_REQ'(1) << lock_id))
                       : (req & ~ack);
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign elig        = req & ~ack;
`endif

    // Rotating priority search: first eligible index at or after ptr,
    // wrapping at NUM_REQ rather than at 2^ID_WIDTH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            idx = sum[ID_WIDTH-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign nxt_ptr = (win == ID_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= '0;
            grant_id <= '0;
            reg_q    <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
`ifdef REG_WRITE_ARB_LOCK_EN
            state    <= IDLE;
            lock_id  <= '0;
`endif
        end else if (found) begin
            reg_q    <= wd[win];
            ack      <= NUM_REQ'(1) << win;
            grant_id <= win;
            busy     <= 1'b1;
`ifdef REG_WRITE_ARB_LOCK_EN
            if (!hold) begin
                ptr <= nxt_ptr;
            end
            if (lock[win]) begin
                state   <= LOCKED;
                lock_id <= win;
            end else begin
                state   <= IDLE;
            end
`else
            ptr      <= nxt_ptr;
`endif
        end else begin
            ack  <= '0;
            busy <= 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
            if (!hold) begin
                state <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    lock = '0;
    logic [DW-1:0]   wd [N];
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [IW-1:0]   grant_id;
    logic [DW-1:0]   reg_q;
    logic            busy;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign wdata[i*DW +: DW] = wd[i];
    end

    reg_write_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (N),
        .ID_WIDTH  (IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .lock    (lock),
        .ack     (ack),
        .grant_id(grant_id),
        .reg_q   (reg_q),
        .busy    (busy)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state as plain integers, winner found by a
    // modular scan starting at the pointer.
    logic [N-1:0]  m_ack = '0;
    logic [IW-1:0] m_gid = '0;
    logic [DW-1:0] m_reg = '0;
    logic          m_busy = 1'b0;
    int            m_ptr = 0;
    int            m_lid = 0;
    bit            m_locked = 1'b0;
    bit            lk_eff;
    int            w, jj, rv, lv, av;
    logic [N-1:0]  req_e = '0;
    bit            rst_e = 1'b0;
    int            waitc [N];

    always @(posedge clk) begin
        req_e = req;
        rst_e = rst;
        if (rst) begin
            m_ack    = '0;
            m_gid    = '0;
            m_reg    = '0;
            m_busy   = 1'b0;
            m_ptr    = 0;
            m_locked = 1'b0;
            m_lid    = 0;
        end else begin
            rv = int'(req);
            lv = int'(lock);
            av = int'(m_ack);
            w  = -1;
`ifdef REG_WRITE_ARB_LOCK_EN
            lk_eff = m_locked && (((lv >> m_lid) & 1) == 1);
`else
            lk_eff = 1'b0;
`endif
            for (int k = 0; k < N; k++) begin
                jj = (m_ptr + k) % N;
                if (w < 0 && ((rv >> jj) & 1) == 1 && ((av >> jj) & 1) == 0
                    && (!lk_eff || jj == m_lid)) begin
                    w = jj;
                end
            end
            if (w >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == w) m_reg = wd[i];
                end
                m_ack  = N'(1 << w);
                m_gid  = IW'(w);
                m_busy = 1'b1;
                if (!lk_eff) m_ptr = (w + 1) % N;
`ifdef REG_WRITE_ARB_LOCK_EN
                m_locked = lk_eff || (((lv >> w) & 1) == 1);
                if (((lv >> w) & 1) == 1) m_lid = w;
`endif
            end else begin
                m_ack    = '0;
                m_busy   = 1'b0;
                m_locked = lk_eff;
            end
        end
    end

    // Every-cycle comparison plus a starvation bound on the DUT's grants.
    always @(negedge clk) begin
        chk("ack", 32'(ack), 32'(m_ack));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("reg_q", reg_q, m_reg);
        chk("busy", 32'(busy), 32'(m_busy));
`ifndef REG_WRITE_ARB_LOCK_EN
        for (int i = 0; i < N; i++) begin
            if (rst_e) begin
                waitc[i] = 0;
            end else if (ack[i]) begin
                n_chk++;
                if (waitc[i] > N - 1) begin
                    n_err++;
                    $display("FAIL fair_wait req%0d: waited %0d grants, max %0d",
                             i, waitc[i], N - 1);
                end
                waitc[i] = 0;
            end else if (req_e[i] && ack != '0) begin
                waitc[i]++;
            end else if (!req_e[i]) begin
                waitc[i] = 0;
            end
        end
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            wd[i]    = '0;
            waitc[i] = 0;
        end

        // Reset then idle
        cyc();
        cyc();
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("idle_ack", 32'(ack), 32'h0);
            chk("idle_reg", reg_q, 32'h0);
            chk("idle_gid", 32'(grant_id), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
        end

        // Single requester: ack every other cycle
        wd[2] = 32'hDEAD_BEEF;
        req   = 4'b0100;
        cyc();
        chk("single_ack1", 32'(ack), 32'h4);
        chk("single_reg1", reg_q, 32'hDEAD_BEEF);
        chk("single_gid", 32'(grant_id), 32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        cyc();
        chk("single_gap_ack", 32'(ack), 32'h0);
        chk("single_gap_busy", 32'(busy), 32'h0);
        chk("single_gap_reg", reg_q, 32'hDEAD_BEEF);
        cyc();
        chk("single_ack2", 32'(ack), 32'h4);
        req = '0;
        cyc();

        // Full contention from a fresh pointer
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) wd[i] = 32'(i + 1);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rot_ack", 32'(ack), 32'(1 << (k % 4)));
            chk("rot_reg", reg_q, 32'((k % 4) + 1));
            chk("rot_busy", 32'(busy), 32'h1);
        end

        // Pointer wrap after a grant to requester 3
        req = 4'b1001;
        cyc();
        chk("wrap_ack0", 32'(ack), 32'h1);
        chk("wrap_reg0", reg_q, 32'h1);
        cyc();
        chk("wrap_ack3", 32'(ack), 32'h8);
        chk("wrap_gid3", 32'(grant_id), 32'h3);
        req = '0;
        cyc();

        // Reset mid-stream
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        cyc();
        chk("mid_gid0", 32'(grant_id), 32'h0);
        cyc();
        chk("mid_gid1", 32'(grant_id), 32'h1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_reg", reg_q, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cyc();
        chk("mid_first_ack", 32'(ack), 32'h1);
        chk("mid_first_reg", reg_q, 32'h1);
        req = '0;
        cyc();

`ifdef REG_WRITE_ARB_LOCK_EN
        // Locked requester 1 starves requester 0 until it unlocks
        rst = 1'b1;
        cyc();
        rst  = 1'b0;
        req  = 4'b0010;
        lock = 4'b0010;
        cyc();
        chk("lock_ack1", 32'(ack), 32'h2);
        req = 4'b0011;
        cyc();
        chk("lock_gap", 32'(ack), 32'h0);
        cyc();
        chk("lock_ack1b", 32'(ack), 32'h2);
        cyc();
        chk("lock_gap2", 32'(ack), 32'h0);
        cyc();
        chk("lock_ack1c", 32'(ack), 32'h2);
        lock = '0;
        cyc();
        chk("unlock_ack0", 32'(ack), 32'h1);
        req = '0;
        cyc();
`endif

        // Randomized traffic honouring the hold-until-ack handshake
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (3000) begin
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else wd[i] = $urandom;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    wd[i]  = $urandom;
                end
            end
`ifdef REG_WRITE_ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = N'($urandom_range(0, 15));
`endif
        end
        rst = 1'b0;
        req = '0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin write arbiter sharing one DATA_WIDTH enable-gated storage register among NUM_REQ requesters. Each requester presents a write request and data. The arbiter picks at most one winner per cycle, loads that requester's data into the internal register and returns a one-cycle ack. Used wherever several pipeline stages or masters must update a single shared status or config register.

Parameters:
- DATA_WIDTH, 32, width of the shared register and of each requester's write data.
- NUM_REQ, 4, number of requesters. Legal range 2..16.
- ID_WIDTH, 2, width of grant_id. Must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- wdata  input  NUM_REQ*DATA_WIDTH  flattened write data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- lock  input  NUM_REQ  per-requester lock request; used only with the optional feature.
- ack  output  NUM_REQ  one-hot, registered; ack[i] high for one cycle means requester i's data was written.
- grant_id  output  ID_WIDTH  registered index of the most recent winner.
- reg_q  output  DATA_WIDTH  current contents of the shared register.
- busy  output  1  registered; high in any cycle after an edge that performed a write.

Behaviour:
Reset:
- Applies at the posedge where rst=1, regardless of req.
- ack=0, grant_id=0, reg_q=0, busy=0, rr pointer=0, FSM=IDLE.

Eligibility:
- elig = req & ~ack. A requester whose ack is currently high is masked, so its still-high req is not double-granted.

Arbitration (each posedge, rst=0):
- Search elig starting at index ptr, ascending, wrapping from NUM_REQ-1 to 0. The first set bit is the winner w.
- If a winner exists:
  - reg_q <= wdata[w]
  - ack <= one-hot(w)
  - grant_id <= w
  - busy <= 1
  - ptr <= (w+1) mod NUM_REQ, wrapping at NUM_REQ, not at 2^ID_WIDTH.
- If elig=0: ack <= 0, busy <= 0; reg_q, grant_id and ptr hold.

Latency and handshake:
- Write data is sampled at the granting edge. reg_q and ack update together, one cycle after the edge.
- A requester must hold req and wdata stable until it sees ack. It may drop req in the ack cycle, or keep req high to issue a new write. The new write is eligible in the cycle after ack.

Throughput:
- One write per cycle when at least two requesters contend.
- A single requester alone writes every other cycle.

Fairness:
- No requester waits more than NUM_REQ-1 grants once its req is high.

Boundary cases:
- All requesters high: grants rotate 0,1,2,3,0,...
- Reset mid-stream: pending acks are dropped. Requesters must re-present their requests after reset.
- ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
Macro: REG_WRITE_ARB_LOCK_EN

Defined:
- FSM has two states, IDLE and LOCKED, plus lock_id.
- IDLE -> LOCKED: on a grant to w while lock[w]=1. lock_id <= w.
- In LOCKED:
  - Only requester lock_id is eligible, still masked by its ack.
  - ptr does not advance.
  - Other requesters stall.
- LOCKED -> IDLE: at the first edge where lock[lock_id]=0. Normal round-robin resumes from the held ptr.
- rst forces IDLE.

Undefined:
- lock is ignored and no LOCKED state is built. Arbitration is pure round-robin.

Test Plan:
1. Reset then idle. rst=1 for 2 cycles, then req=0 → ack=0, reg_q=0, grant_id=0, busy=0 throughout.
2. Single requester. req=4'b0100, wdata[2]=32'hDEAD_BEEF held high → ack=4'b0100 on alternate cycles, reg_q=32'hDEAD_BEEF after the first ack, grant_id=2.
3. Full contention. req=4'b1111, wdata[i]=i+1, held 8 cycles → ack sequence 0001,0010,0100,1000,0001,...; reg_q follows 1,2,3,4,1,...; busy=1 continuously.
4. Pointer wrap and fairness. After a grant to requester 3, assert req=4'b1001 → next grant is requester 0, then requester 3.
5. Reset mid-stream. req=4'b1111 running, rst=1 for one cycle after the grant to requester 1 → next cycle ack=0, reg_q=0. After rst drops, the first grant goes to requester 0.
6. Lock (REG_WRITE_ARB_LOCK_EN defined). req=4'b0011, lock=4'b0010, with requester 1 winning first → only requester 1 acked on alternate cycles while lock[1]=1. Requester 0 starves. After lock[1]=0, requester 0 is acked next.
